any1_sel_split: RTL

Parametrised successor to the opcode-driven byte-select decoder. It accepts one memory request (address, size code, direction, store data) and generates per-lane byte selects for a BUS_BYTES-wide data bus. Accesses that cross a bus-width boundary are split into two sequential bus cycles. For loads, returned data from those cycles is merged and right-aligned. It sits between the load/store issue logic and the bus interface unit.

---
 rtl/any1_pkg.sv | 23 ++
 rtl/any1_sel_split_if.sv | 45 ++++
 rtl/any1_sel_mask.sv | 29 ++
 rtl/any1_sel_split.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/any1_pkg.sv
// Shared definitions for the any1 load/store path: size codes, the
// byte-select sequencer state encoding and a size-to-length helper.
package any1_pkg;

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_WYDE  = 3'd1;
    localparam logic [2:0] SZ_TETRA = 3'd2;
    localparam logic [2:0] SZ_OCTA  = 3'd3;
    localparam logic [2:0] SZ_HEXI  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        ACK0,
        REQ1,
        ACK1
    } sel_state_t;

    function automatic int unsigned size_bytes(input logic [2:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/any1_sel_split_if.sv
// Request, bus-cycle and completion signals of the byte-select splitter.
// The slave modport is the splitter's view; master is the surrounding logic.
interface any1_sel_split_if #(
    parameter int BUS_BYTES = 16,
    parameter int ADDR_W    = 32
);

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [ADDR_W-1:0]        req_adr_i;
    logic [2:0]               req_size_i;
    logic                     req_we_i;
    logic [BUS_BYTES*8-1:0]   req_dat_i;

    logic                     cyc_valid_o;
    logic                     cyc_ready_i;
    logic [ADDR_W-1:0]        cyc_adr_o;
    logic [BUS_BYTES-1:0]     cyc_sel_o;
    logic                     cyc_we_o;
    logic [BUS_BYTES*8-1:0]   cyc_dat_o;
    logic                     cyc_last_o;
    logic                     ack_i;
    logic [BUS_BYTES*8-1:0]   rd_dat_i;

    logic                     done_o;
    logic [BUS_BYTES*8-1:0]   ld_dat_o;
    logic                     size_err_o;

    modport slave (
        input  req_valid_i, req_adr_i, req_size_i, req_we_i, req_dat_i,
        input  cyc_ready_i, ack_i, rd_dat_i,
        output req_ready_o,
        output cyc_valid_o, cyc_adr_o, cyc_sel_o, cyc_we_o, cyc_dat_o, cyc_last_o,
        output done_o, ld_dat_o, size_err_o
    );

    modport master (
        output req_valid_i, req_adr_i, req_size_i, req_we_i, req_dat_i,
        output cyc_ready_i, ack_i, rd_dat_i,
        input  req_ready_o,
        input  cyc_valid_o, cyc_adr_o, cyc_sel_o, cyc_we_o, cyc_dat_o, cyc_last_o,
        input  done_o, ld_dat_o, size_err_o
    );

endinterface

// File: rtl/any1_sel_mask.sv
// Combinational lane-mask generator: double-width byte mask for an access of
// 1<<size bytes starting at lane 'off', plus the matching data shift in bits.
module any1_sel_mask
    import any1_pkg::*;
#(
    parameter  int BUS_BYTES = 16,
    localparam int LB        = $clog2(BUS_BYTES)
) (
    input  logic [LB-1:0]          off,
    input  logic [2:0]             size,
    output logic [2*BUS_BYTES-1:0] mask2,
    output logic [LB+2:0]          shamt
);

    int unsigned len;

    always_comb begin
        len   = size_bytes(size);
        mask2 = '0;
        for (int i = 0; i < 2*BUS_BYTES; i++) begin
            if (i >= int'(off) && i < int'(off) + int'(len)) begin
                mask2[i] = 1'b1;
            end
        end
    end

    assign shamt = {off, 3'b000};

endmodule

// File: rtl/any1_sel_split.sv
// Byte-select sequencer: turns one load/store request into one or two
// bus-aligned cycles and right-aligns the merged load data on completion.
module any1_sel_split
    import any1_pkg::*;
#(
    parameter int BUS_BYTES = 16,
    parameter int ADDR_W    = 32,
    parameter int MAX_SIZE  = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    any1_sel_split_if.slave bus
);

    localparam int          LB     = $clog2(BUS_BYTES);
    localparam int          DW     = BUS_BYTES*8;
    localparam logic [2:0]  MAX_SZ = 3'(MAX_SIZE);
    localparam logic [LB:0] BB_L   = (LB+1)'(BUS_BYTES);

    sel_state_t             state_q, state_d;
    logic [ADDR_W-1:0]      adr_q;
    logic [2:0]             size_q;
    logic                   we_q;
    logic [2*BUS_BYTES-1:0] mask_q, mask_in;
    logic [2*DW-1:0]        dat_q, dat_in;
    logic [LB+2:0]          shamt_in;
    logic [DW-1:0]          merge_q, ld_q, keep, lo_part, hi_part, merged;
    logic                   done_q, err_q;
    logic                   accept, legal, last0;
    logic [ADDR_W-1:0]      base_adr;
    logic [LB-1:0]          off_q;
    logic [LB+3:0]          hi_shamt;

    any1_sel_mask #(.BUS_BYTES(BUS_BYTES)) u_mask (
        .off   (bus.req_adr_i[LB-1:0]),
        .size  (bus.req_size_i),
        .mask2 (mask_in),
        .shamt (shamt_in)
    );

    assign accept   = bus.req_valid_i & bus.req_ready_o;
    assign legal    = (bus.req_size_i <= MAX_SZ);
    assign dat_in   = {{DW{1'b0}}, bus.req_dat_i} << shamt_in;
    assign off_q    = adr_q[LB-1:0];
    assign base_adr = {adr_q[ADDR_W-1:LB], {LB{1'b0}}};
    assign last0    = (mask_q[2*BUS_BYTES-1:BUS_BYTES] == '0);

    // The second cycle's lanes continue where the first cycle's shifted-down data ends.
    assign hi_shamt = {BB_L - {1'b0, off_q}, 3'b000};
    assign lo_part  = bus.rd_dat_i >> {off_q, 3'b000};
    assign hi_part  = bus.rd_dat_i << hi_shamt;
    assign merged   = merge_q | hi_part;

    always_comb begin
        keep = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            if (i < int'(size_bytes(size_q))) begin
                keep[i*8 +: 8] = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && legal) state_d = REQ0;
            REQ0:    if (bus.cyc_ready_i) state_d = ACK0;
            ACK0:    if (bus.ack_i)       state_d = last0 ? IDLE : REQ1;
            REQ1:    if (bus.cyc_ready_i) state_d = ACK1;
            ACK1:    if (bus.ack_i)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = (state_q == IDLE);
        bus.cyc_valid_o = 1'b0;
        bus.cyc_adr_o   = '0;
        bus.cyc_sel_o   = '0;
        bus.cyc_dat_o   = '0;
        bus.cyc_we_o    = 1'b0;
        bus.cyc_last_o  = 1'b0;
        case (state_q)
            REQ0: begin
                bus.cyc_valid_o = 1'b1;
                bus.cyc_adr_o   = base_adr;
                bus.cyc_sel_o   = mask_q[BUS_BYTES-1:0];
                bus.cyc_dat_o   = dat_q[DW-1:0];
                bus.cyc_we_o    = we_q;
                bus.cyc_last_o  = last0;
            end
            REQ1: begin
                bus.cyc_valid_o = 1'b1;
                bus.cyc_adr_o   = base_adr + ADDR_W'(BUS_BYTES);
                bus.cyc_sel_o   = mask_q[2*BUS_BYTES-1:BUS_BYTES];
                bus.cyc_dat_o   = dat_q[2*DW-1:DW];
                bus.cyc_we_o    = we_q;
                bus.cyc_last_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.done_o     = done_q;
    assign bus.ld_dat_o   = ld_q;
    assign bus.size_err_o = err_q;

    // Request capture, load merging and the registered completion/error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            adr_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            mask_q  <= '0;
            dat_q   <= '0;
            merge_q <= '0;
            ld_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                adr_q   <= bus.req_adr_i;
                size_q  <= bus.req_size_i;
                we_q    <= bus.req_we_i;
                mask_q  <= mask_in;
                dat_q   <= dat_in;
                merge_q <= '0;
                err_q   <= !legal;
            end
            if (state_q == ACK0 && bus.ack_i) begin
                merge_q <= we_q ? '0 : lo_part;
                if (last0) begin
                    done_q <= 1'b1;
                    ld_q   <= we_q ? '0 : (lo_part & keep);
                end
            end
            if (state_q == ACK1 && bus.ack_i) begin
                done_q <= 1'b1;
                ld_q   <= we_q ? '0 : (merged & keep);
            end
        end
    end

endmodule
